ex_lsu_skid_reg: RTL and testbench

- Receiving end of the EXU output interface: captures the EX data and control messages into the EX→LSU pipeline boundary.
- Uses a 2-entry skid buffer with valid/ready handshakes on both sides, so a downstream LSU stall never creates a combinational ready path back into EXU.
- Answers the EXU forwarding queries (ex_rf_raddr1/ex_rf_raddr2) with the youngest matching in-flight ALU result.

---
 rtl/ex_lsu_skid_reg.sv | 155 +++++++++++++++
 tb/tb_ex_lsu_skid_reg.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ex_lsu_skid_reg.sv
// EX->LSU pipeline boundary: 2-entry skid buffer (head H, skid S) with youngest-first
// register forwarding. Optional stall counter enabled by EX_LSU_STALL_CNT_EN.
module ex_lsu_skid_reg #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_rf_we,
  input  logic [4:0]        in_rf_waddr,
  input  logic [XLEN-1:0]   in_fwd_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  input  logic [4:0]        fwd_raddr1,
  input  logic [4:0]        fwd_raddr2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [XLEN-1:0]   fwd_data1,
  output logic [XLEN-1:0]   fwd_data2
`ifdef EX_LSU_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  logic              h_vld_q, h_vld_d, s_vld_q, s_vld_d;
  logic [DATA_W-1:0] h_data_q, h_data_d, s_data_q, s_data_d;
  logic [CTRL_W-1:0] h_ctrl_q, h_ctrl_d, s_ctrl_q, s_ctrl_d;
  logic              h_we_q, h_we_d, s_we_q, s_we_d;
  logic [4:0]        h_waddr_q, h_waddr_d, s_waddr_q, s_waddr_d;
  logic [XLEN-1:0]   h_fwd_q, h_fwd_d, s_fwd_q, s_fwd_d;
  logic              accept, pop;

  // in_ready comes straight from a flop so LSU stalls never reach EXU combinationally
  assign in_ready  = ~s_vld_q;
  assign out_valid = h_vld_q;
  assign out_data  = h_data_q;
  assign out_ctrl  = h_ctrl_q;
  assign accept    = in_valid & in_ready;
  assign pop       = h_vld_q & out_ready;

  always_comb begin
    h_vld_d   = h_vld_q;
    h_data_d  = h_data_q;
    h_ctrl_d  = h_ctrl_q;
    h_we_d    = h_we_q;
    h_waddr_d = h_waddr_q;
    h_fwd_d   = h_fwd_q;
    s_vld_d   = s_vld_q;
    s_data_d  = s_data_q;
    s_ctrl_d  = s_ctrl_q;
    s_we_d    = s_we_q;
    s_waddr_d = s_waddr_q;
    s_fwd_d   = s_fwd_q;
    if (flush) begin
      h_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (!h_vld_q || pop) begin
      if (s_vld_q) begin
        h_vld_d   = 1'b1;
        h_data_d  = s_data_q;
        h_ctrl_d  = s_ctrl_q;
        h_we_d    = s_we_q;
        h_waddr_d = s_waddr_q;
        h_fwd_d   = s_fwd_q;
        s_vld_d   = 1'b0;
      end else if (accept) begin
        h_vld_d   = 1'b1;
        h_data_d  = in_data;
        h_ctrl_d  = in_ctrl;
        h_we_d    = in_rf_we;
        h_waddr_d = in_rf_waddr;
        h_fwd_d   = in_fwd_val;
      end else begin
        h_vld_d = 1'b0;
      end
    end else if (accept) begin
      s_vld_d   = 1'b1;
      s_data_d  = in_data;
      s_ctrl_d  = in_ctrl;
      s_we_d    = in_rf_we;
      s_waddr_d = in_rf_waddr;
      s_fwd_d   = in_fwd_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_vld_q   <= 1'b0;
      h_data_q  <= '0;
      h_ctrl_q  <= '0;
      h_we_q    <= 1'b0;
      h_waddr_q <= '0;
      h_fwd_q   <= '0;
      s_vld_q   <= 1'b0;
      s_data_q  <= '0;
      s_ctrl_q  <= '0;
      s_we_q    <= 1'b0;
      s_waddr_q <= '0;
      s_fwd_q   <= '0;
    end else begin
      h_vld_q   <= h_vld_d;
      h_data_q  <= h_data_d;
      h_ctrl_q  <= h_ctrl_d;
      h_we_q    <= h_we_d;
      h_waddr_q <= h_waddr_d;
      h_fwd_q   <= h_fwd_d;
      s_vld_q   <= s_vld_d;
      s_data_q  <= s_data_d;
      s_ctrl_q  <= s_ctrl_d;
      s_we_q    <= s_we_d;
      s_waddr_q <= s_waddr_d;
      s_fwd_q   <= s_fwd_d;
    end
  end

  logic h_m1, s_m1, h_m2, s_m2;

  // S is younger than H, so an S match shadows an H match
  always_comb begin
    h_m1 = h_vld_q & h_we_q & (h_waddr_q == fwd_raddr1) & (fwd_raddr1 != 5'd0);
    s_m1 = s_vld_q & s_we_q & (s_waddr_q == fwd_raddr1) & (fwd_raddr1 != 5'd0);
    h_m2 = h_vld_q & h_we_q & (h_waddr_q == fwd_raddr2) & (fwd_raddr2 != 5'd0);
    s_m2 = s_vld_q & s_we_q & (s_waddr_q == fwd_raddr2) & (fwd_raddr2 != 5'd0);
    fwd_hit1  = h_m1 | s_m1;
    fwd_hit2  = h_m2 | s_m2;
    fwd_data1 = s_m1 ? s_fwd_q : (h_m1 ? h_fwd_q : '0);
    fwd_data2 = s_m2 ? s_fwd_q : (h_m2 ? h_fwd_q : '0);
  end

`ifdef EX_LSU_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (h_vld_q && !out_ready) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_ex_lsu_skid_reg.sv
// Directed self-checking bench for ex_lsu_skid_reg; inputs driven and outputs checked
// on the falling edge, away from the active rising edge.
module tb_ex_lsu_skid_reg;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [31:0]  in_ctrl = '0;
  logic         in_rf_we = 1'b0;
  logic [4:0]   in_rf_waddr = '0;
  logic [31:0]  in_fwd_val = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic [31:0]  out_ctrl;
  logic         flush = 1'b0;
  logic [4:0]   fwd_raddr1 = '0;
  logic [4:0]   fwd_raddr2 = '0;
  logic         fwd_hit1, fwd_hit2;
  logic [31:0]  fwd_data1, fwd_data2;
`ifdef EX_LSU_STALL_CNT_EN
  logic [31:0]  stall_cycles;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ex_lsu_skid_reg dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr), .in_fwd_val(in_fwd_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .flush(flush), .fwd_raddr1(fwd_raddr1), .fwd_raddr2(fwd_raddr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
`ifdef EX_LSU_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  function automatic logic [127:0] mk(input int i);
    logic [31:0] w;
    w = 32'h0000_0100 + 32'(i);
    return {w, ~w, w, ~w};
  endfunction

  task automatic drive(input logic v, input int i, input logic we, input logic [4:0] wa,
                       input logic [31:0] fv);
    in_valid = v; in_data = mk(i); in_ctrl = 32'hC000_0000 + 32'(i);
    in_rf_we = we; in_rf_waddr = wa; in_fwd_val = fv;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    fwd_raddr1 = '0; fwd_raddr2 = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; fwd_raddr1 = 5'd5; fwd_raddr2 = 5'd9;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_data !== 128'h0) begin bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    total++; if (out_ctrl !== 32'h0) begin bad++; $display("FAIL reset_out_ctrl: got %h want 0", out_ctrl); end
    total++; if (fwd_hit1 !== 1'b0 || fwd_hit2 !== 1'b0) begin bad++; $display("FAIL reset_fwd_hit: got %b%b want 00", fwd_hit1, fwd_hit2); end
    do_reset();
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 0, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, out_valid); end
      total++; if (out_data !== mk(i)) begin bad++; $display("FAIL b2b_data[%0d]: got %h want %h", i, out_data, mk(i)); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); end
      if (i < 3) drive(1'b1, i + 1, 1'b0, 5'd0, 32'h0);
      else in_valid = 1'b0;
    end
    total++; if (out_ctrl !== 32'hC000_0003) begin bad++; $display("FAIL b2b_ctrl: got %h want c0000003", out_ctrl); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 10, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    total++; if (out_data !== mk(10) || out_valid !== 1'b1) begin bad++; $display("FAIL stall_a: got %h/%b want %h/1", out_data, out_valid, mk(10)); end
    drive(1'b1, 11, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_skid_full: got %b want 0", in_ready); end
    drive(1'b1, 12, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    total++; if (in_ready !== 1'b0 || out_data !== mk(10)) begin bad++; $display("FAIL stall_hold: got %b/%h want 0/%h", in_ready, out_data, mk(10)); end
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (out_data !== mk(11) || in_ready !== 1'b1) begin bad++; $display("FAIL stall_b: got %h/%b want %h/1", out_data, in_ready, mk(11)); end
    @(negedge clk);
    total++; if (out_data !== mk(12) || out_valid !== 1'b1) begin bad++; $display("FAIL stall_c: got %h/%b want %h/1", out_data, out_valid, mk(12)); end
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_forward_and_flush();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 20, 1'b1, 5'd5, 32'h11);
    @(negedge clk);
    drive(1'b1, 21, 1'b1, 5'd5, 32'h22);
    @(negedge clk);
    in_valid = 1'b0; fwd_raddr1 = 5'd5; fwd_raddr2 = 5'd7;
    #1;
    total++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'h22) begin bad++; $display("FAIL fwd_youngest: got %b/%h want 1/00000022", fwd_hit1, fwd_data1); end
    total++; if (fwd_hit2 !== 1'b0 || fwd_data2 !== 32'h0) begin bad++; $display("FAIL fwd_miss: got %b/%h want 0/0", fwd_hit2, fwd_data2); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 22, 1'b1, 5'd0, 32'h33);
    @(negedge clk);
    in_valid = 1'b0; fwd_raddr2 = 5'd0;
    #1;
    total++; if (fwd_hit2 !== 1'b0 || fwd_data2 !== 32'h0) begin bad++; $display("FAIL fwd_x0: got %b/%h want 0/0", fwd_hit2, fwd_data2); end
    total++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'h22) begin bad++; $display("FAIL fwd_head: got %b/%h want 1/00000022", fwd_hit1, fwd_data1); end
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL flush_pre_full: got %b/%b want 0/1", in_ready, out_valid); end
    flush = 1'b1;
    drive(1'b1, 23, 1'b1, 5'd5, 32'h44);
    @(negedge clk);
    flush = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_clear: got %b/%b want 0/1", out_valid, in_ready); end
    total++; if (fwd_hit1 !== 1'b0) begin bad++; $display("FAIL flush_fwd: got %b want 0", fwd_hit1); end
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_dropped: got %b want 0", out_valid); end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0; fwd_raddr1 = 5'd9;
    drive(1'b1, 30, 1'b1, 5'd9, 32'h55);
    @(negedge clk);
    drive(1'b1, 31, 1'b1, 5'd9, 32'h66);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'h66 || out_valid !== 1'b1) begin bad++; $display("FAIL arst_pre: got %b/%h/%b want 1/00000066/1", fwd_hit1, fwd_data1, out_valid); end
    #1 rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || fwd_hit1 !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL arst_immediate: got %b/%b/%b want 0/0/1", out_valid, fwd_hit1, in_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

`ifdef EX_LSU_STALL_CNT_EN
  task automatic test_stall_cnt();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 40, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL stallcnt_start: got %0d want 0", stall_cycles); end
    repeat (7) @(negedge clk);
    total++; if (stall_cycles !== 32'd7) begin bad++; $display("FAIL stallcnt_seven: got %0d want 7", stall_cycles); end
    #2 rst = 1'b1;
    #1;
    total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL stallcnt_reset: got %0d want 0", stall_cycles); end
    @(negedge clk);
    rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_forward_and_flush();
    test_async_reset();
`ifdef EX_LSU_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
